vga_pattern_gen: RTL and testbench

Pixel source for the VGA pipeline. Sits directly upstream of the VGA timing controller: consumes its scan coordinates `x`/`y` and returns the 6-bit `colour` word it serialises to the DAC. The block draws a solid square that bounces inside the 640x480 active area over a fixed background. It also cycles the colour of the left-hand strip once every `STRIP_PERIOD` frames. All motion updates happen once per frame, during vertical blanking.

---
 rtl/vga_pkg.sv | 31 +++
 rtl/vga_pattern_gen_if.sv | 27 ++
 rtl/vga_bounce_axis.sv | 56 +++++
 rtl/vga_pattern_gen.sv | 111 +++++++++++
 tb/tb_vga_pattern_gen.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing constants, 3-bit {B,G,R} colours and
// bounce direction encoding for the pattern generator slice.
package vga_pkg;

  localparam logic [9:0] H_ACTIVE = 10'd640;
  localparam logic [9:0] V_ACTIVE = 10'd480;
  localparam logic [9:0] H_TOTAL  = 10'd800;
  localparam logic [9:0] V_TOTAL  = 10'd525;

  typedef logic [2:0] rgb_t;

  localparam rgb_t RGB_BLACK   = 3'b000;
  localparam rgb_t RGB_RED     = 3'b001;
  localparam rgb_t RGB_GREEN   = 3'b010;
  localparam rgb_t RGB_YELLOW  = 3'b011;
  localparam rgb_t RGB_BLUE    = 3'b100;
  localparam rgb_t RGB_MAGENTA = 3'b101;
  localparam rgb_t RGB_CYAN    = 3'b110;
  localparam rgb_t RGB_WHITE   = 3'b111;

  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_t;

  // Strip palette walks 1..7 and skips black.
  function automatic rgb_t next_strip(rgb_t c);
    return (c == RGB_WHITE) ? RGB_RED : rgb_t'(c + 3'd1);
  endfunction

endpackage

// File: rtl/vga_pattern_gen_if.sv
// vga_pattern_gen_if: scan coordinates and run in, colour word and
// frame tick out. master = timing controller side, slave = generator.
interface vga_pattern_gen_if;

  logic [9:0] x;
  logic [9:0] y;
  logic       run;
  logic [5:0] colour;
  logic       frame_tick;

  modport master (
    output x,
    output y,
    output run,
    input  colour,
    input  frame_tick
  );

  modport slave (
    input  x,
    input  y,
    input  run,
    output colour,
    output frame_tick
  );

endinterface

// File: rtl/vga_bounce_axis.sv
// vga_bounce_axis: position/direction of the square on one axis.
// Ports: vga_clock, resetn, step_en (one update), pos (0..LIMIT).
module vga_bounce_axis
  import vga_pkg::*;
#(
  parameter logic [10:0] LIMIT = 11'd608,
  parameter logic [10:0] STEP  = 11'd2
) (
  input  logic       vga_clock,
  input  logic       resetn,
  input  logic       step_en,
  output logic [9:0] pos
);

  dir_t       dir;
  dir_t       dir_nx;
  logic [9:0] pos_nx;
  logic [10:0] pos_w;

  // Compares run at 11 bits so pos + STEP can never wrap.
  assign pos_w = {1'b0, pos};

  always_comb begin
    pos_nx = pos;
    dir_nx = dir;
    unique case (dir)
      DIR_POS: begin
        if (pos_w + STEP >= LIMIT) begin
          pos_nx = LIMIT[9:0];
          dir_nx = DIR_NEG;
        end else begin
          pos_nx = pos + STEP[9:0];
        end
      end
      DIR_NEG: begin
        if (pos_w <= STEP) begin
          pos_nx = '0;
          dir_nx = DIR_POS;
        end else begin
          pos_nx = pos - STEP[9:0];
        end
      end
    endcase
  end

  always_ff @(posedge vga_clock or negedge resetn) begin
    if (!resetn) begin
      pos <= '0;
      dir <= DIR_POS;
    end else if (step_en) begin
      pos <= pos_nx;
      dir <= dir_nx;
    end
  end

endmodule

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: bouncing square over a background plus a colour-cycling
// left strip. Ports: vga_clock, resetn, bus (x, y, run -> colour, frame_tick).
// Optional white frame border: define VGA_PATTERN_BORDER_EN.
module vga_pattern_gen #(
  parameter logic [9:0] H_ACTIVE     = vga_pkg::H_ACTIVE,
  parameter logic [9:0] V_ACTIVE     = vga_pkg::V_ACTIVE,
  parameter logic [9:0] BOX_SIZE     = 10'd32,
  parameter logic [9:0] STEP         = 10'd2,
  parameter logic [2:0] BOX_RGB      = 3'b010,
  parameter logic [2:0] BG_RGB       = 3'b100,
  parameter logic [7:0] STRIP_PERIOD = 8'd60
) (
  input  logic              vga_clock,
  input  logic              resetn,
  vga_pattern_gen_if.slave  bus
);

  import vga_pkg::*;

  localparam logic [10:0] X_LIM    = {1'b0, H_ACTIVE} - {1'b0, BOX_SIZE};
  localparam logic [10:0] Y_LIM    = {1'b0, V_ACTIVE} - {1'b0, BOX_SIZE};
  localparam logic [10:0] STEP_W   = {1'b0, STEP};
  localparam logic [10:0] BOX_W    = {1'b0, BOX_SIZE};
  localparam logic [7:0]  CNT_LAST = STRIP_PERIOD - 8'd1;

  logic       frame_evt;
  logic       step_en;
  logic [9:0] box_x;
  logic [9:0] box_y;
  logic [7:0] frame_cnt;
  rgb_t       strip_rgb;
  logic       active;
  logic       in_box;
  rgb_t       main_rgb;
  logic [5:0] colour_d;
  logic [10:0] px;
  logic [10:0] py;

  // First clock of vertical blanking.
  assign frame_evt = (bus.x == 10'd0) && (bus.y == V_ACTIVE);
  assign step_en   = frame_evt & bus.run;

  vga_bounce_axis #(
    .LIMIT (X_LIM),
    .STEP  (STEP_W)
  ) u_axis_x (
    .vga_clock (vga_clock),
    .resetn    (resetn),
    .step_en   (step_en),
    .pos       (box_x)
  );

  vga_bounce_axis #(
    .LIMIT (Y_LIM),
    .STEP  (STEP_W)
  ) u_axis_y (
    .vga_clock (vga_clock),
    .resetn    (resetn),
    .step_en   (step_en),
    .pos       (box_y)
  );

  always_ff @(posedge vga_clock or negedge resetn) begin
    if (!resetn) begin
      frame_cnt <= '0;
      strip_rgb <= RGB_RED;
    end else if (step_en) begin
      if (frame_cnt == CNT_LAST) begin
        frame_cnt <= '0;
        strip_rgb <= next_strip(strip_rgb);
      end else begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  assign px = {1'b0, bus.x};
  assign py = {1'b0, bus.y};

  assign active = (bus.x < H_ACTIVE) && (bus.y < V_ACTIVE);

  assign in_box = (px >= {1'b0, box_x}) &&
                  (px <  {1'b0, box_x} + BOX_W) &&
                  (py >= {1'b0, box_y}) &&
                  (py <  {1'b0, box_y} + BOX_W);

  always_comb begin
    main_rgb = in_box ? BOX_RGB : BG_RGB;
`ifdef VGA_PATTERN_BORDER_EN
    if (bus.x == 10'd0 || bus.x == H_ACTIVE - 10'd1 ||
        bus.y == 10'd0 || bus.y == V_ACTIVE - 10'd1) begin
      main_rgb = RGB_WHITE;
    end
`endif
    colour_d = '0;
    if (active) begin
      colour_d = {main_rgb, strip_rgb};
    end
  end

  always_ff @(posedge vga_clock or negedge resetn) begin
    if (!resetn) begin
      bus.colour     <= '0;
      bus.frame_tick <= 1'b0;
    end else begin
      bus.colour     <= colour_d;
      bus.frame_tick <= frame_evt;
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen: drives scan coordinates directly and checks colour
// and frame_tick against a closed-form bounce/strip model.
module tb_vga_pattern_gen;

  localparam int HA   = 640;
  localparam int VA   = 480;
  localparam int BOX  = 32;
  localparam int STP  = 2;
  localparam int PER  = 2;
  localparam int XLIM = HA - BOX;
  localparam int YLIM = VA - BOX;

  logic clk;
  logic resetn;
  int   tests;
  int   fails;
  int   n;

  vga_pattern_gen_if bus ();

  vga_pattern_gen #(
    .STRIP_PERIOD (8'(PER))
  ) dut (
    .vga_clock (clk),
    .resetn    (resetn),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Unfolded bounce: a triangle wave of period 2*lim.
  function automatic int tri_pos(int k, int lim);
    int m;
    m = (k * STP) % (2 * lim);
    return (m <= lim) ? m : 2 * lim - m;
  endfunction

  function automatic logic [5:0] exp_colour(int px, int py);
    int bx;
    int by;
    logic [2:0] main;
    logic [2:0] strip;
    if (px >= HA || py >= VA) return 6'd0;
    bx = tri_pos(n, XLIM);
    by = tri_pos(n, YLIM);
    strip = 3'(1 + (n / PER) % 7);
    if (px >= bx && px < bx + BOX && py >= by && py < by + BOX)
      main = 3'b010;
    else
      main = 3'b100;
`ifdef VGA_PATTERN_BORDER_EN
    if (px == 0 || px == HA - 1 || py == 0 || py == VA - 1)
      main = 3'b111;
`endif
    return {main, strip};
  endfunction

  task automatic probe(input int px, input int py, input string tag);
    logic [5:0] e;
    @(negedge clk);
    bus.x = 10'(px);
    bus.y = 10'(py);
    @(negedge clk);
    e = exp_colour(px, py);
    tests++;
    if (bus.colour !== e) begin
      fails++;
      $display("FAIL %s colour (%0d,%0d) n=%0d: got %b want %b",
               tag, px, py, n, bus.colour, e);
    end
    tests++;
    if (bus.frame_tick !== 1'b0) begin
      fails++;
      $display("FAIL %s tick_idle: got %b want 0", tag, bus.frame_tick);
    end
  endtask

  task automatic probe_box(input string tag);
    int bx;
    int by;
    bx = tri_pos(n, XLIM);
    by = tri_pos(n, YLIM);
    probe(bx, by, tag);
    probe(bx + BOX - 1, by + BOX - 1, tag);
    probe(bx + BOX, by, tag);
    probe(bx, by + BOX, tag);
    if (bx > 0) probe(bx - 1, by, tag);
    if (by > 0) probe(bx, by - 1, tag);
  endtask

  task automatic frames(input bit r, input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      tests++;
      if (bus.frame_tick !== 1'b0) begin
        fails++;
        $display("FAIL frames tick_idle: got %b want 0", bus.frame_tick);
      end
      bus.x   = 10'd0;
      bus.y   = 10'd480;
      bus.run = r;
      @(negedge clk);
      tests++;
      if (bus.frame_tick !== 1'b1) begin
        fails++;
        $display("FAIL frames tick_pulse: got %b want 1", bus.frame_tick);
      end
      bus.x = 10'd1;
      if (r) n++;
    end
  endtask

  task automatic test_reset();
    tests++;
    if (bus.colour !== 6'd0 || bus.frame_tick !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: got %b/%b want 0/0",
               bus.colour, bus.frame_tick);
    end
    @(negedge clk);
    resetn = 1'b1;
    n = 0;
    probe(0, 0, "reset_origin");
    probe(32, 0, "reset_right");
    probe(31, 31, "reset_inner");
    probe(0, 32, "reset_below");
  endtask

  task automatic test_frame_scan();
    int  px;
    int  py;
    bit  pe;
    int  ticks;
    logic [5:0] e;
    ticks = 0;
    @(negedge clk);
    bus.run = 1'b1;
    bus.x = 10'd0;
    bus.y = 10'd479;
    px = 0;
    py = 479;
    pe = 1'b0;
    for (int yy = 479; yy <= 481; yy++) begin
      for (int xx = 0; xx < 800; xx++) begin
        if (!(yy == 479 && xx == 0)) begin
          @(negedge clk);
          e = exp_colour(px, py);
          tests++;
          if (bus.colour !== e) begin
            fails++;
            $display("FAIL scan colour (%0d,%0d): got %b want %b",
                     px, py, bus.colour, e);
          end
          tests++;
          if (bus.frame_tick !== pe) begin
            fails++;
            $display("FAIL scan tick at (%0d,%0d): got %b want %b",
                     xx, yy, bus.frame_tick, pe);
          end
          if (bus.frame_tick === 1'b1) ticks++;
          if (pe) n++;
          bus.x = 10'(xx);
          bus.y = 10'(yy);
          px = xx;
          py = yy;
          pe = (xx == 0 && yy == VA);
        end
      end
    end
    @(negedge clk);
    if (bus.frame_tick === 1'b1) ticks++;
    tests++;
    if (ticks != 1) begin
      fails++;
      $display("FAIL scan tick_count: got %0d want 1", ticks);
    end
    probe_box("scan_next_frame");
    probe(2, 2, "scan_at_2_2");
  endtask

  task automatic test_bounce_x();
    frames(1'b1, 304 - n);
    probe_box("bounce_at_608");
    probe(XLIM + BOX - 1, tri_pos(n, YLIM), "bounce_edge");
    frames(1'b1, 1);
    probe_box("bounce_back_606");
  endtask

  task automatic test_run_hold();
    frames(1'b0, 3);
    probe_box("hold_pos");
    probe(10, 300, "hold_strip");
    frames(1'b1, 1);
    probe_box("hold_resume");
  endtask

  task automatic test_corner();
    frames(1'b1, 8512 - n);
    probe_box("corner_at_0");
    frames(1'b1, 1);
    probe_box("corner_after");
    probe(2, 2, "corner_2_2");
  endtask

  task automatic test_async_reset();
    logic [5:0] e;
    frames(1'b1, 5);
    @(negedge clk);
    bus.x = 10'd5;
    bus.y = 10'd5;
    e = exp_colour(5, 5);
    @(posedge clk);
    #1;
    tests++;
    if (bus.colour !== e) begin
      fails++;
      $display("FAIL areset_pre colour: got %b want %b", bus.colour, e);
    end
    #1 resetn = 1'b0;
    #1;
    tests++;
    if (bus.colour !== 6'd0) begin
      fails++;
      $display("FAIL areset_colour: got %b want 0", bus.colour);
    end
    @(negedge clk);
    resetn = 1'b1;
    n = 0;
    bus.x = 10'd0;
    bus.y = 10'd480;
    bus.run = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (bus.frame_tick !== 1'b1) begin
      fails++;
      $display("FAIL areset_pre tick: got %b want 1", bus.frame_tick);
    end
    #1 resetn = 1'b0;
    #1;
    tests++;
    if (bus.frame_tick !== 1'b0) begin
      fails++;
      $display("FAIL areset_tick: got %b want 0", bus.frame_tick);
    end
    @(negedge clk);
    bus.x = 10'd1;
    resetn = 1'b1;
    n = 0;
    probe_box("areset_origin");
    frames(1'b1, 1);
    probe_box("areset_first_step");
  endtask

  task automatic test_boundary();
    probe(639, 100, "edge_right");
    probe(640, 100, "edge_outside");
    probe(0, 100, "edge_left");
    probe(100, 0, "edge_top");
    probe(639, 479, "edge_corner");
    probe(639, 480, "edge_below");
    probe(799, 524, "edge_far");
  endtask

  task automatic test_random();
    int sel;
    int px;
    int py;
    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 3);
      if (sel == 0) begin
        frames(1'($urandom_range(0, 1)), $urandom_range(1, 20));
      end else if (sel == 1) begin
        probe_box("rand_box");
      end else begin
        px = $urandom_range(0, 799);
        py = $urandom_range(0, 524);
        if (px == 0 && py == VA) py = 0;
        probe(px, py, "rand_pixel");
      end
    end
  endtask

  initial begin
    clk     = 1'b0;
    resetn  = 1'b0;
    tests   = 0;
    fails   = 0;
    n       = 0;
    bus.x   = 10'd1;
    bus.y   = 10'd480;
    bus.run = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    test_frame_scan();
    test_bounce_x();
    test_run_hold();
    test_corner();
    test_boundary();
    test_async_reset();
    test_random();
    test_boundary();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
